// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - shared FSM states, CSR addresses and cause codes for trap sequencing
package trap_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_TVAL,
        ST_REDIR,
        ST_RET
    } trap_state_e;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_FAST_BASE = 5'd16;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_controller_irq_priority_encoder.sv
// rtl/trap_controller_irq_priority_encoder.sv - picks the highest-priority enabled pending interrupt
module trap_controller_irq_priority_encoder
    import trap_controller_pkg::*;
#(
    parameter int NUM_FAST_IRQ = 16
) (
    input  logic        irq_external_i,
    input  logic        irq_timer_i,
    input  logic        irq_software_i,
    input  logic [15:0] irq_fast_i,
    input  logic [31:0] mie_i,
    output logic        irq_valid_o,
    output logic [4:0]  irq_cause_o
);

    logic unused_mie;
    assign unused_mie = ^{mie_i[15:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    // Later assignments override earlier ones, so sources are visited lowest priority first.
    always_comb begin
        irq_valid_o = 1'b0;
        irq_cause_o = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i < NUM_FAST_IRQ && irq_fast_i[i] && mie_i[16+i]) begin
                irq_valid_o = 1'b1;
                irq_cause_o = CAUSE_FAST_BASE + 5'(i);
            end
        end
        if (irq_timer_i && mie_i[7]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = CAUSE_MTI;
        end
        if (irq_software_i && mie_i[3]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = CAUSE_MSI;
        end
        if (irq_external_i && mie_i[11]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = CAUSE_MEI;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap entry / MRET sequencer driving the CSR write port and PC redirect
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int NUM_FAST_IRQ = 16,
    parameter bit VECTORED_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic [31:0] pc_value,
    input  logic [31:0] pc_next,
    input  logic        irq_external,
    input  logic        irq_timer,
    input  logic        irq_software,
    input  logic [15:0] irq_fast,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        csr_wr_en,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_wr_data,
    output logic        stall,
    output logic        flush,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_target,
    output logic        mstatus_mie,
    output logic        mstatus_mpie
);

    trap_state_e state_q;
    logic        is_irq_q;
    logic [4:0]  cause_q;
    logic [31:0] tval_q;
    logic        csr_wr_en_q;
    logic [11:0] csr_wr_addr_q;
    logic [31:0] csr_wr_data_q;
    logic        redir_valid_q;
    logic [31:0] redir_target_q;
    logic        mie_q;
    logic        mpie_q;

    logic        irq_valid;
    logic [4:0]  irq_cause;
    logic        idle, take_exc, take_mret, take_irq;
    logic [31:0] trap_target;

    trap_controller_irq_priority_encoder #(
        .NUM_FAST_IRQ(NUM_FAST_IRQ)
    ) u_irq_enc (
        .irq_external_i(irq_external),
        .irq_timer_i   (irq_timer),
        .irq_software_i(irq_software),
        .irq_fast_i    (irq_fast),
        .mie_i         (mie),
        .irq_valid_o   (irq_valid),
        .irq_cause_o   (irq_cause)
    );

    // Acceptance only happens in IDLE, which is what masks interrupts mid-sequence.
    assign idle      = (state_q == ST_IDLE);
    assign take_exc  = idle && exc_valid;
    assign take_mret = idle && !exc_valid && mret_valid;
    assign take_irq  = idle && !exc_valid && !mret_valid && mie_q && irq_valid;

    always_comb begin
        trap_target = align4(mtvec);
        if (VECTORED_EN && mtvec[1:0] == 2'b01 && is_irq_q)
            trap_target = trap_target + {25'd0, cause_q, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            is_irq_q       <= 1'b0;
            cause_q        <= 5'd0;
            tval_q         <= 32'd0;
            csr_wr_en_q    <= 1'b0;
            csr_wr_addr_q  <= 12'd0;
            csr_wr_data_q  <= 32'd0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= 32'd0;
            mie_q          <= 1'b0;
            mpie_q         <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_exc || take_irq) begin
                        state_q       <= ST_W_EPC;
                        is_irq_q      <= take_irq;
                        cause_q       <= take_exc ? exc_cause : irq_cause;
                        tval_q        <= take_exc ? exc_tval : 32'd0;
                        csr_wr_en_q   <= 1'b1;
                        csr_wr_addr_q <= CSR_MEPC;
                        csr_wr_data_q <= align4(take_exc ? pc_value : pc_next);
                    end else if (take_mret) begin
                        state_q        <= ST_RET;
                        redir_valid_q  <= 1'b1;
                        redir_target_q <= align4(mepc);
                    end
                end
                ST_W_EPC: begin
                    state_q       <= ST_W_CAUSE;
                    csr_wr_addr_q <= CSR_MCAUSE;
                    csr_wr_data_q <= {is_irq_q, 26'd0, cause_q};
                end
                ST_W_CAUSE: begin
                    state_q       <= ST_W_TVAL;
                    csr_wr_addr_q <= CSR_MTVAL;
                    csr_wr_data_q <= tval_q;
                end
                ST_W_TVAL: begin
                    state_q        <= ST_REDIR;
                    csr_wr_en_q    <= 1'b0;
                    csr_wr_addr_q  <= 12'd0;
                    csr_wr_data_q  <= 32'd0;
                    redir_valid_q  <= 1'b1;
                    redir_target_q <= trap_target;
                end
                ST_REDIR: begin
                    state_q       <= ST_IDLE;
                    redir_valid_q <= 1'b0;
                    mpie_q        <= mie_q;
                    mie_q         <= 1'b0;
                end
                ST_RET: begin
                    state_q       <= ST_IDLE;
                    redir_valid_q <= 1'b0;
                    mie_q         <= mpie_q;
                    mpie_q        <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign csr_wr_en          = csr_wr_en_q;
    assign csr_wr_addr        = csr_wr_addr_q;
    assign csr_wr_data        = csr_wr_data_q;
    assign stall              = !idle;
    assign flush              = take_exc || take_irq || take_mret;
    assign pc_redirect_valid  = redir_valid_q;
    assign pc_redirect_target = redir_target_q;
    assign mstatus_mie        = mie_q;
    assign mstatus_mpie       = mpie_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed bench for trap_controller
module tb_trap_controller;

    logic        clk, reset;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic [31:0] pc_value, pc_next;
    logic        irq_external, irq_timer, irq_software;
    logic [15:0] irq_fast;
    logic [31:0] mie, mtvec, mepc;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        stall, flush, pc_redirect_valid;
    logic [31:0] pc_redirect_target;
    logic        mstatus_mie, mstatus_mpie;

    int errors = 0;
    int total  = 0;

    trap_controller #(.NUM_FAST_IRQ(16), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .pc_value(pc_value), .pc_next(pc_next),
        .irq_external(irq_external), .irq_timer(irq_timer), .irq_software(irq_software),
        .irq_fast(irq_fast), .mie(mie), .mtvec(mtvec), .mepc(mepc),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .stall(stall), .flush(flush),
        .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_mret(input string tag, input logic [31:0] epc, input logic [31:0] target);
        mepc       = epc;
        mret_valid = 1'b1;
        #1;
        chk({tag, "/flush"}, {31'd0, flush}, 32'd1);
        tick();
        mret_valid = 1'b0;
        chk({tag, "/redir_v"}, {31'd0, pc_redirect_valid}, 32'd1);
        chk({tag, "/redir_t"}, pc_redirect_target, target);
        tick();
        chk({tag, "/redir_off"}, {31'd0, pc_redirect_valid}, 32'd0);
        chk({tag, "/mie"}, {31'd0, mstatus_mie}, 32'd1);
        chk({tag, "/mpie"}, {31'd0, mstatus_mpie}, 32'd1);
    endtask

    // Called in the acceptance cycle; scrambles the sampled inputs to prove they were latched.
    task automatic expect_trap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                               input logic [31:0] tval, input logic [31:0] target);
        tick();
        exc_valid = 1'b0;
        exc_cause = 5'd0;
        exc_tval  = 32'h0BAD_0BAD;
        pc_value  = 32'hFFFF_FFF0;
        pc_next   = 32'hFFFF_FFF4;
        #1;
        chk({tag, "/epc_en"}, {31'd0, csr_wr_en}, 32'd1);
        chk({tag, "/epc_addr"}, {20'd0, csr_wr_addr}, 32'h341);
        chk({tag, "/epc_data"}, csr_wr_data, epc);
        chk({tag, "/stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "/no_flush"}, {31'd0, flush}, 32'd0);
        tick();
        chk({tag, "/cause_addr"}, {20'd0, csr_wr_addr}, 32'h342);
        chk({tag, "/cause_data"}, csr_wr_data, cause);
        tick();
        chk({tag, "/tval_addr"}, {20'd0, csr_wr_addr}, 32'h343);
        chk({tag, "/tval_data"}, csr_wr_data, tval);
        tick();
        chk({tag, "/redir_en"}, {31'd0, csr_wr_en}, 32'd0);
        chk({tag, "/redir_v"}, {31'd0, pc_redirect_valid}, 32'd1);
        chk({tag, "/redir_t"}, pc_redirect_target, target);
        chk({tag, "/redir_stall"}, {31'd0, stall}, 32'd1);
        tick();
        chk({tag, "/done_v"}, {31'd0, pc_redirect_valid}, 32'd0);
        chk({tag, "/done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "/done_mie"}, {31'd0, mstatus_mie}, 32'd0);
        chk({tag, "/done_mpie"}, {31'd0, mstatus_mpie}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        exc_valid = 1'b0; exc_cause = 5'd0; exc_tval = 32'd0;
        mret_valid = 1'b0; pc_value = 32'd0; pc_next = 32'd0;
        irq_external = 1'b0; irq_timer = 1'b0; irq_software = 1'b0; irq_fast = 16'd0;
        mie = 32'd0; mtvec = 32'd0; mepc = 32'd0;
        tick();
        tick();
        chk("rst/stall", {31'd0, stall}, 32'd0);
        chk("rst/wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("rst/wr_addr", {20'd0, csr_wr_addr}, 32'd0);
        chk("rst/wr_data", csr_wr_data, 32'd0);
        chk("rst/redir_v", {31'd0, pc_redirect_valid}, 32'd0);
        chk("rst/redir_t", pc_redirect_target, 32'd0);
        chk("rst/mie", {31'd0, mstatus_mie}, 32'd0);
        chk("rst/mpie", {31'd0, mstatus_mpie}, 32'd1);
        reset = 1'b0;

        // Enable interrupts through MRET; misaligned mepc is rounded down.
        do_mret("mret0", 32'h0000_0043, 32'h0000_0040);

        // 1: ecall
        mtvec = 32'h0000_0200;
        exc_valid = 1'b1; exc_cause = 5'd11; pc_value = 32'h100; pc_next = 32'h104; exc_tval = 32'd0;
        #1;
        chk("ecall/flush", {31'd0, flush}, 32'd1);
        chk("ecall/stall0", {31'd0, stall}, 32'd0);
        expect_trap("ecall", 32'h100, 32'h0000_000B, 32'd0, 32'h200);

        // 2: timer interrupt, vectored mtvec
        do_mret("mret1", 32'h104, 32'h104);
        mtvec = 32'h0000_0201; mie = 32'h0000_0080; pc_next = 32'h84; pc_value = 32'h80;
        irq_timer = 1'b1;
        #1;
        chk("timer/flush", {31'd0, flush}, 32'd1);
        expect_trap("timer", 32'h84, 32'h8000_0007, 32'd0, 32'h21C);
        irq_timer = 1'b0;

        // 3: external interrupt masked until MRET sets MIE
        mie = 32'h0000_0800; irq_external = 1'b1;
        #1;
        chk("mask/flush", {31'd0, flush}, 32'd0);
        tick();
        chk("mask/stall_a", {31'd0, stall}, 32'd0);
        tick();
        chk("mask/stall_b", {31'd0, stall}, 32'd0);
        pc_next = 32'h500;
        do_mret("mret2", 32'h300, 32'h300);
        chk("ext/flush", {31'd0, flush}, 32'd1);
        expect_trap("ext", 32'h500, 32'h8000_000B, 32'd0, 32'h22C);
        irq_external = 1'b0;

        // 4: exception and timer in the same cycle
        do_mret("mret3", 32'h600, 32'h600);
        mie = 32'h0000_0080; irq_timer = 1'b1;
        exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF; pc_value = 32'h700; pc_next = 32'h704;
        #1;
        chk("ill/flush", {31'd0, flush}, 32'd1);
        expect_trap("ill", 32'h700, 32'h0000_0002, 32'hDEAD_BEEF, 32'h200);
        tick();
        chk("ill/timer_held", {31'd0, stall}, 32'd0);
        pc_next = 32'h704;
        do_mret("mret4", 32'h704, 32'h704);
        chk("tim2/flush", {31'd0, flush}, 32'd1);
        expect_trap("tim2", 32'h704, 32'h8000_0007, 32'd0, 32'h21C);
        irq_timer = 1'b0;

        // 5: fast interrupts, then software outranks them
        mie = 32'hFFFF_0008;
        do_mret("mret5", 32'h800, 32'h800);
        irq_fast = 16'h0208; pc_next = 32'h900;
        #1;
        chk("fast/flush", {31'd0, flush}, 32'd1);
        expect_trap("fast", 32'h900, 32'h8000_0013, 32'd0, 32'h24C);
        irq_software = 1'b1; pc_next = 32'h904;
        do_mret("mret6", 32'h904, 32'h904);
        chk("msi/flush", {31'd0, flush}, 32'd1);
        expect_trap("msi", 32'h904, 32'h8000_0003, 32'd0, 32'h20C);
        irq_software = 1'b0; irq_fast = 16'd0;

        // 6: exception with MIE=0 beats a simultaneous MRET, then reset in W_CAUSE
        exc_valid = 1'b1; exc_cause = 5'd3; exc_tval = 32'hA00; pc_value = 32'hA00;
        mret_valid = 1'b1; mepc = 32'h1234;
        #1;
        chk("rst6/flush", {31'd0, flush}, 32'd1);
        tick();
        exc_valid = 1'b0; mret_valid = 1'b0;
        chk("rst6/epc_en", {31'd0, csr_wr_en}, 32'd1);
        chk("rst6/epc_data", csr_wr_data, 32'hA00);
        chk("rst6/no_ret", {31'd0, pc_redirect_valid}, 32'd0);
        tick();
        chk("rst6/cause_data", csr_wr_data, 32'h0000_0003);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst6/stall", {31'd0, stall}, 32'd0);
        chk("rst6/wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("rst6/mie", {31'd0, mstatus_mie}, 32'd0);
        chk("rst6/mpie", {31'd0, mstatus_mpie}, 32'd1);
        tick();
        chk("rst6/no_redir", {31'd0, pc_redirect_valid}, 32'd0);
        chk("rst6/idle", {31'd0, stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
